// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the IF/LS memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] MEMW_NONE = 2'b00;
  localparam logic [1:0] MEMW_BYTE = 2'b01;
  localparam logic [1:0] MEMW_WORD = 2'b10;
  localparam logic       OWNER_IF  = 1'b0;
  localparam logic       OWNER_LS  = 1'b1;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  we;
    logic [15:0] wdata;
  } cmd_t;

  // 2'b11 is not a legal write code and degrades to a read
  function automatic logic [1:0] norm_we(input logic [1:0] we);
    return (we == 2'b11) ? MEMW_NONE : we;
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// Winner select: LS has priority unless IF has waited through the starvation limit.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic starve_hit,
  output logic grant,
  output logic owner
);
  assign grant = if_req | ls_req;
  assign owner = (ls_req && !(if_req && starve_hit)) ? OWNER_LS : OWNER_IF;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        ls_req,
  input  logic [15:0] ls_addr,
  input  logic [1:0]  ls_we,
  input  logic [15:0] ls_wdata,
  output logic        ls_ack,
  output logic [15:0] ls_rdata,
  output logic [7:0]  ls_rbyte,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_writew,
  output logic [7:0]  mem_writeb,
  output logic [1:0]  mem_memw,
  input  logic [15:0] mem_word,
  input  logic [7:0]  mem_byte,
  output logic        busy,
  output logic        owner
);
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state;
  cmd_t          cmd;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic          grant, pick_owner;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .starve_hit (starve == STARVE_MAX),
    .grant      (grant),
    .owner      (pick_owner)
  );

  assign busy       = (state != IDLE);
  assign mem_addr   = cmd.addr;
  assign mem_writew = cmd.wdata;
  assign mem_writeb = cmd.wdata[7:0];
  // write strobe only on the last access cycle; reset forces IDLE so it drops at once
  assign mem_memw   = (state == ACCESS && cnt == '0) ? cmd.we : MEMW_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd      <= '0;
      cnt      <= '0;
      starve   <= '0;
      owner    <= OWNER_IF;
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
      ls_rbyte <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) starve <= '0;
          if (grant) begin
            owner <= pick_owner;
            cnt   <= CNT_INIT;
            state <= ACCESS;
            if (pick_owner == OWNER_LS) begin
              cmd <= '{addr: ls_addr, we: norm_we(ls_we), wdata: ls_wdata};
              if (if_req && starve != STARVE_MAX) starve <= starve + SW'(1);
            end else begin
              cmd    <= '{addr: if_addr, we: MEMW_NONE, wdata: 16'h0};
              starve <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (owner == OWNER_LS) begin
              ls_rdata <= mem_word;
              ls_rbyte <= mem_byte;
              ls_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_word;
              if_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed corner cases plus random transactions against a memory-level model.
module tb_mem_arbiter;
  logic clk, rst_a, rst_b;
  int checks = 0, errors = 0;

  // DUT A: ACCESS_CYCLES=1, STARVE_LIMIT=4
  logic        a_if_req, a_ls_req, a_if_ack, a_ls_ack, a_busy, a_owner;
  logic [15:0] a_if_addr, a_ls_addr, a_ls_wdata, a_if_rdata, a_ls_rdata, a_maddr, a_ww, a_word;
  logic [1:0]  a_ls_we, a_memw;
  logic [7:0]  a_ls_rbyte, a_wb, a_byte;
  // DUT B: ACCESS_CYCLES=3
  logic        b_if_req, b_ls_req, b_if_ack, b_ls_ack, b_busy, b_owner;
  logic [15:0] b_if_addr, b_ls_addr, b_ls_wdata, b_if_rdata, b_ls_rdata, b_maddr, b_ww, b_word;
  logic [1:0]  b_ls_we, b_memw;
  logic [7:0]  b_ls_rbyte, b_wb, b_byte;

  mem_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst_a),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_addr(a_ls_addr), .ls_we(a_ls_we), .ls_wdata(a_ls_wdata),
    .ls_ack(a_ls_ack), .ls_rdata(a_ls_rdata), .ls_rbyte(a_ls_rbyte),
    .mem_addr(a_maddr), .mem_writew(a_ww), .mem_writeb(a_wb), .mem_memw(a_memw),
    .mem_word(a_word), .mem_byte(a_byte), .busy(a_busy), .owner(a_owner));

  mem_arbiter #(.ACCESS_CYCLES(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_addr(b_ls_addr), .ls_we(b_ls_we), .ls_wdata(b_ls_wdata),
    .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata), .ls_rbyte(b_ls_rbyte),
    .mem_addr(b_maddr), .mem_writew(b_ww), .mem_writeb(b_wb), .mem_memw(b_memw),
    .mem_word(b_word), .mem_byte(b_byte), .busy(b_busy), .owner(b_owner));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] seed(int i);
    case (i)
      3: return 16'hFF00;
      4: return 16'hBEEF;
      6: return 16'h1111;
      default: return 16'(i * 16'h9E37 ^ 16'h5A5A);
    endcase
  endfunction

  // memories: preloaded on the first edge, then written by the DUT strobes
  logic [15:0] mema [0:255];
  logic [15:0] memb [0:255];
  logic [15:0] refm [0:255];
  bit loaded_a = 0, loaded_b = 0;
  int a_wr_cnt = 0;
  assign a_word = mema[a_maddr[7:0]];
  assign a_byte = a_word[7:0];
  assign b_word = memb[b_maddr[7:0]];
  assign b_byte = b_word[7:0];

  always @(posedge clk) begin
    if (!loaded_a) begin
      for (int i = 0; i < 256; i++) mema[i] <= seed(i);
      loaded_a <= 1;
    end else if (a_memw == 2'b10) mema[a_maddr[7:0]] <= a_ww;
    else if (a_memw == 2'b01) mema[a_maddr[7:0]][7:0] <= a_wb;
    if (a_memw != 2'b00) a_wr_cnt <= a_wr_cnt + 1;
  end

  always @(posedge clk) begin
    if (!loaded_b) begin
      for (int i = 0; i < 256; i++) memb[i] <= seed(i);
      loaded_b <= 1;
    end else if (b_memw == 2'b10) memb[b_maddr[7:0]] <= b_ww;
    else if (b_memw == 2'b01) memb[b_maddr[7:0]][7:0] <= b_wb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one isolated transaction on DUT A, checked against the memory-level model
  task automatic access_a(input bit is_ls, input logic [15:0] addr, input logic [1:0] we,
                          input logic [15:0] wd, input string tag);
    logic [15:0] exp;
    int wr0, cyc, expw;
    bit got;
    @(negedge clk);
    exp = refm[addr[7:0]];
    wr0 = a_wr_cnt;
    if (is_ls) begin
      a_ls_addr = addr; a_ls_we = we; a_ls_wdata = wd; a_ls_req = 1;
    end else begin
      a_if_addr = addr; a_if_req = 1;
    end
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      got = is_ls ? a_ls_ack : a_if_ack;
    end
    a_if_req = 0; a_ls_req = 0;
    chk({tag, "_ack"}, 32'(got), 1);
    chk({tag, "_lat"}, cyc, 2);
    expw = (is_ls && (we == 2'b10 || we == 2'b01)) ? 1 : 0;
    chk({tag, "_wrcnt"}, a_wr_cnt - wr0, expw);
    if (is_ls) begin
      chk({tag, "_rdata"}, a_ls_rdata, exp);
      chk({tag, "_rbyte"}, a_ls_rbyte, exp[7:0]);
      chk({tag, "_owner"}, a_owner, 1);
      if (we == 2'b10) refm[addr[7:0]] = wd;
      else if (we == 2'b01) refm[addr[7:0]][7:0] = wd[7:0];
    end else begin
      chk({tag, "_rdata"}, a_if_rdata, exp);
      chk({tag, "_owner"}, a_owner, 0);
    end
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, 32'(a_if_ack | a_ls_ack), 0);
  endtask

  initial begin
    bit ackseen, who, exp_who, got;
    int k, cyc;
    for (int i = 0; i < 256; i++) refm[i] = seed(i);
    rst_a = 0; rst_b = 0;
    a_if_req = 0; a_if_addr = 0; a_ls_req = 0; a_ls_addr = 0; a_ls_we = 0; a_ls_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_addr = 0; b_ls_we = 0; b_ls_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_ack", a_if_ack, 0);
    chk("rst_ls_ack", a_ls_ack, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_ls_rdata", a_ls_rdata, 0);
    chk("rst_memw", a_memw, 0);
    chk("rst_maddr", a_maddr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_owner", a_owner, 0);
    @(negedge clk);
    rst_a = 1; rst_b = 1;

    // reset lands while a word store sits in its final access cycle
    @(negedge clk);
    a_ls_addr = 16'h0006; a_ls_we = 2'b10; a_ls_wdata = 16'h5A5A; a_ls_req = 1;
    @(posedge clk); #1;
    chk("t1_memw_pending", a_memw, 2'b10);
    rst_a = 0;
    #1;
    chk("t1_memw_async", a_memw, 0);
    chk("t1_busy", a_busy, 0);
    a_ls_req = 0;
    ackseen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      ackseen |= a_ls_ack;
    end
    chk("t1_noack", 32'(ackseen), 0);
    chk("t1_mem", mema[6], 16'h1111);
    @(negedge clk);
    rst_a = 1;

    access_a(0, 16'h0004, 2'b00, 16'h0, "t2_if");
    chk("t2_beef", a_if_rdata, 16'hBEEF);

    access_a(1, 16'h0002, 2'b10, 16'h1234, "t3_st");
    access_a(1, 16'h0002, 2'b00, 16'h0, "t3_ld");
    chk("t3_val", a_ls_rdata, 16'h1234);

    access_a(1, 16'h0003, 2'b01, 16'h77AB, "t4_stb");
    chk("t4_mem", mema[3], 16'hFFAB);

    // both requesters held: LS wins until IF has waited STARVE_LIMIT grants
    a_if_addr = 16'h0008; a_ls_addr = 16'h0009; a_ls_we = 2'b00;
    @(negedge clk);
    a_if_req = 1; a_ls_req = 1;
    k = 0;
    for (int g = 0; g < 10; g++) begin
      cyc = 0; got = 0;
      while (!got && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        got = a_if_ack | a_ls_ack;
      end
      chk($sformatf("t5_ack%0d", g), 32'(got), 1);
      who = a_ls_ack;
      if (k == 4) begin exp_who = 0; k = 0; end
      else begin exp_who = 1; k++; end
      chk($sformatf("t5_grant%0d", g), 32'(who), 32'(exp_who));
      if (who) begin chk($sformatf("t5_lsd%0d", g), a_ls_rdata, refm[9]); a_ls_req = 0; end
      else begin chk($sformatf("t5_ifd%0d", g), a_if_rdata, refm[8]); a_if_req = 0; end
      @(posedge clk);
      @(negedge clk);
      a_if_req = 1; a_ls_req = 1;
    end
    a_if_req = 0; a_ls_req = 0;
    repeat (4) @(posedge clk);

    for (int n = 0; n < 40; n++) begin
      access_a(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               16'($urandom), $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mema[i], refm[i]);

    // three-cycle access: address held throughout, strobe only on the last cycle
    @(negedge clk);
    b_ls_addr = 16'h0005; b_ls_we = 2'b10; b_ls_wdata = 16'hC0DE; b_ls_req = 1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e <= 3) begin
        chk($sformatf("t6_addr%0d", e), b_maddr, 16'h0005);
        chk($sformatf("t6_memw%0d", e), b_memw, (e == 3) ? 2'b10 : 2'b00);
      end
      chk($sformatf("t6_ack%0d", e), b_ls_ack, (e == 4) ? 1 : 0);
    end
    b_ls_req = 0;
    chk("t6_ldata", b_ls_rdata, seed(5));
    @(posedge clk); #1;
    chk("t6_mem", memb[5], 16'hC0DE);
    chk("t6_idle", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
